// File: rtl/hyperram_reg_responder.sv
// hyperram_reg_responder: Avalon-MM HyperRAM device model with ID/CR registers, CR0-driven initial latency and word memory
module hyperram_reg_responder #(
    parameter int          G_MEM_ADDR_BITS = 8,
    parameter logic [15:0] G_ID0           = 16'h0C81,
    parameter logic [15:0] G_ID1           = 16'h0001,
    parameter logic [15:0] G_CR0_RESET     = 16'h8F1F,
    parameter logic [15:0] G_CR1_RESET     = 16'hFFC1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        s_avm_write_i,
    input  logic        s_avm_read_i,
    input  logic [31:0] s_avm_address_i,
    input  logic [15:0] s_avm_writedata_i,
    input  logic [1:0]  s_avm_byteenable_i,
    input  logic [7:0]  s_avm_burstcount_i,
    output logic [15:0] s_avm_readdata_o,
    output logic        s_avm_readdatavalid_o,
    output logic        s_avm_waitrequest_o,
    output logic [3:0]  cfg_latency_o,
    output logic        cfg_fixed_o,
    output logic [2:0]  cfg_drive_o
);
    typedef enum logic [2:0] {IDLE, LAT, WRITE, RACK, RDATA} state_t;
    state_t state, state_nx;
    logic [15:0] mem [2**G_MEM_ADDR_BITS];
    logic [15:0] cr0, cr1, rd_word;
    logic [G_MEM_ADDR_BITS-1:0] ma;
    logic [7:0] rsel, cnt;
    logic [3:0] lat_l, lat_n, lat_cnt;
    logic sp, dir_wr, req, last, beat_wr, rd_adv, is_id, is_cr, unused;

    always_comb begin
        case (cr0[7:4])
            4'd0:    lat_l = 4'd5;
            4'd1:    lat_l = 4'd6;
            4'd2:    lat_l = 4'd7;
            4'd14:   lat_l = 4'd3;
            4'd15:   lat_l = 4'd4;
            default: lat_l = 4'd6;
        endcase
    end

    assign cfg_latency_o = lat_l;
    assign cfg_fixed_o   = cr0[3];
    assign cfg_drive_o   = cr0[14:12];
    assign lat_n   = s_avm_address_i[31] ? 4'd0 : (cr0[3] ? {lat_l[2:0], 1'b0} : lat_l);
    assign req     = s_avm_write_i | s_avm_read_i;
    assign last    = cnt == 8'd1;
    assign beat_wr = state == WRITE && s_avm_write_i;
    assign rd_adv  = state == RACK || (state == RDATA && !last);
    assign is_id   = sp && rsel == 8'd0;
    assign is_cr   = sp && rsel == 8'd1;
    assign rd_word = is_id ? (ma[0] ? G_ID1 : G_ID0) :
                     is_cr ? (ma[0] ? cr1 : cr0) :
                     sp    ? 16'h0000 : mem[ma];
    assign unused  = ^s_avm_address_i;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = lat_n != 4'd0 ? LAT : (s_avm_write_i ? WRITE : RACK);
            LAT:     if (lat_cnt == 4'd0) state_nx = dir_wr ? WRITE : RACK;
            WRITE:   if (s_avm_write_i && last) state_nx = IDLE;
            RACK:    state_nx = RDATA;
            RDATA:   if (last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state                 <= IDLE;
            s_avm_waitrequest_o   <= 1'b1;
            s_avm_readdatavalid_o <= 1'b0;
            s_avm_readdata_o      <= 16'h0000;
            cr0                   <= G_CR0_RESET;
            cr1                   <= G_CR1_RESET;
            sp                    <= 1'b0;
            rsel                  <= 8'd0;
            ma                    <= '0;
            cnt                   <= 8'd0;
            dir_wr                <= 1'b0;
            lat_cnt               <= 4'd0;
        end else begin
            state                 <= state_nx;
            s_avm_waitrequest_o   <= !(state_nx == WRITE || state_nx == RACK);
            s_avm_readdatavalid_o <= state_nx == RDATA;
            if (state == IDLE && req) begin
                sp      <= s_avm_address_i[31];
                rsel    <= s_avm_address_i[18:11];
                ma      <= s_avm_address_i[G_MEM_ADDR_BITS-1:0];
                cnt     <= s_avm_burstcount_i == 8'd0 ? 8'd1 : s_avm_burstcount_i;
                dir_wr  <= s_avm_write_i;
                lat_cnt <= lat_n - 4'd1;
            end
            if (state == LAT) lat_cnt <= lat_cnt - 4'd1;
            if (rd_adv) s_avm_readdata_o <= rd_word;
            // register beats keep hitting the same register
            if ((beat_wr || rd_adv) && !sp) ma <= ma + 1'b1;
            if (beat_wr || state == RDATA) cnt <= cnt - 8'd1;
            if (beat_wr && is_cr && !ma[0]) begin
                if (s_avm_byteenable_i[0]) cr0[7:0]  <= s_avm_writedata_i[7:0];
                if (s_avm_byteenable_i[1]) cr0[15:8] <= s_avm_writedata_i[15:8];
            end
            if (beat_wr && is_cr && ma[0]) begin
                if (s_avm_byteenable_i[0]) cr1[7:0]  <= s_avm_writedata_i[7:0];
                if (s_avm_byteenable_i[1]) cr1[15:8] <= s_avm_writedata_i[15:8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (beat_wr && !sp) begin
            if (s_avm_byteenable_i[0]) mem[ma][7:0]  <= s_avm_writedata_i[7:0];
            if (s_avm_byteenable_i[1]) mem[ma][15:8] <= s_avm_writedata_i[15:8];
        end
    end
endmodule

// File: tb/tb_hyperram_reg_responder.sv
// tb_hyperram_reg_responder: scoreboard bench for the HyperRAM register/memory responder
module tb_hyperram_reg_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        write = 1'b0, read = 1'b0;
    logic [31:0] address = '0;
    logic [15:0] writedata = '0;
    logic [1:0]  byteenable = 2'b11;
    logic [7:0]  burstcount = 8'd1;
    logic [15:0] readdata;
    logic        readdatavalid, waitrequest;
    logic [3:0]  cfg_latency;
    logic        cfg_fixed;
    logic [2:0]  cfg_drive;

    int tests = 0, fails = 0, beats = 0;
    logic [15:0] exp_q[$];
    logic [15:0] wq[$];

    always #5 clk = ~clk;

    hyperram_reg_responder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .s_avm_write_i(write), .s_avm_read_i(read),
        .s_avm_address_i(address), .s_avm_writedata_i(writedata),
        .s_avm_byteenable_i(byteenable), .s_avm_burstcount_i(burstcount),
        .s_avm_readdata_o(readdata), .s_avm_readdatavalid_o(readdatavalid),
        .s_avm_waitrequest_o(waitrequest),
        .cfg_latency_o(cfg_latency), .cfg_fixed_o(cfg_fixed), .cfg_drive_o(cfg_drive)
    );

    // every returned beat is matched against the oldest expected word
    always @(negedge clk) begin : monitor
        logic [15:0] e;
        if (readdatavalid) begin
            beats++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL rdata unexpected beat got %h", readdata);
            end else begin
                e = exp_q.pop_front();
                if (readdata !== e) begin
                    fails++;
                    $display("FAIL rdata got %h expected %h", readdata, e);
                end
            end
        end
    end

    task automatic avm_write(input logic [31:0] a, input logic [1:0] be, input logic [7:0] bc, output int waits);
        int n, guard;
        n = (bc == 8'd0) ? 1 : int'(bc);
        waits = 0;
        guard = 0;
        @(posedge clk); #1;
        write = 1'b1; address = a; byteenable = be; burstcount = bc; writedata = wq.pop_front();
        while (n > 0 && guard < 100) begin
            @(negedge clk);
            if (waitrequest) begin
                waits++;
                @(posedge clk); #1;
            end else begin
                @(posedge clk); #1;
                n--;
                if (n > 0) writedata = wq.pop_front();
            end
            guard++;
        end
        write = 1'b0;
        tests++;
        if (n != 0) begin
            fails++;
            $display("FAIL write_timeout addr %h beats_left %0d expected 0", a, n);
        end
    endtask

    task automatic avm_read_cmd(input logic [31:0] a, input logic [7:0] bc);
        int guard;
        guard = 0;
        @(posedge clk); #1;
        read = 1'b1; address = a; burstcount = bc;
        while (guard < 100) begin
            @(negedge clk);
            if (!waitrequest) break;
            guard++;
        end
        @(posedge clk); #1;
        read = 1'b0;
        tests++;
        if (guard >= 100) begin
            fails++;
            $display("FAIL read_accept addr %h never accepted", a);
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL read_drain missing %0d beats expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic avm_read(input logic [31:0] a, input logic [7:0] bc);
        avm_read_cmd(a, bc);
        wait_drain();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({waitrequest, readdatavalid, readdata} !== {1'b1, 1'b0, 16'h0000}) begin
            fails++;
            $display("FAIL reset_outputs got wr=%b rdv=%b rd=%h expected 1 0 0000", waitrequest, readdatavalid, readdata);
        end
        tests++;
        if ({cfg_latency, cfg_fixed, cfg_drive} !== {4'd6, 1'b1, 3'd0}) begin
            fails++;
            $display("FAIL reset_cfg got L=%0d f=%b d=%0d expected 6 1 0", cfg_latency, cfg_fixed, cfg_drive);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_latency_burst();
        int w;
        for (int i = 1; i <= 4; i++) wq.push_back(16'(i));
        avm_write(32'h10, 2'b11, 8'd4, w);
        tests++;
        if (w != 13) begin
            fails++;
            $display("FAIL default_latency waits got %0d expected 13", w);
        end
        for (int i = 1; i <= 4; i++) exp_q.push_back(16'(i));
        avm_read(32'h10, 8'd4);
    endtask

    task automatic test_byteenable();
        int w;
        wq.push_back(16'hAAAA);
        avm_write(32'h10, 2'b11, 8'd1, w);
        wq.push_back(16'h1234);
        avm_write(32'h10, 2'b01, 8'd1, w);
        exp_q.push_back(16'hAA34);
        avm_read(32'h10, 8'd1);
        wq.push_back(16'h5555);
        avm_write(32'h20, 2'b11, 8'd0, w);
        exp_q.push_back(16'h5555);
        avm_read(32'h20, 8'd0);
    endtask

    task automatic test_wrap();
        int w;
        wq.push_back(16'd5);
        wq.push_back(16'd6);
        avm_write(32'hFF, 2'b11, 8'd2, w);
        exp_q.push_back(16'd6);
        avm_read(32'h00, 8'd1);
        exp_q.push_back(16'd5);
        avm_read(32'hFF, 8'd1);
        exp_q.push_back(16'd5);
        exp_q.push_back(16'd6);
        avm_read(32'hFF, 8'd2);
        exp_q.push_back(16'd6);
        avm_read(32'h0000_0100, 8'd1);
    endtask

    task automatic test_cfg();
        int w;
        logic [15:0] cr [3];
        int lat [3], fx [3], drv [3], wt [3];
        cr  = '{16'hFFF7, 16'h8F0F, 16'h0027};
        lat = '{4, 5, 7};
        fx  = '{0, 1, 0};
        drv = '{7, 0, 0};
        wt  = '{5, 11, 8};
        for (int i = 0; i < 3; i++) begin
            wq.push_back(cr[i]);
            avm_write(32'h8000_0800, 2'b11, 8'd1, w);
            tests++;
            if (w != 1) begin
                fails++;
                $display("FAIL cr0_write_waits got %0d expected 1", w);
            end
            @(negedge clk);
            tests++;
            if (cfg_latency !== 4'(lat[i]) || cfg_fixed !== 1'(fx[i]) || cfg_drive !== 3'(drv[i])) begin
                fails++;
                $display("FAIL cfg got L=%0d f=%b d=%0d expected %0d %0d %0d", cfg_latency, cfg_fixed, cfg_drive, lat[i], fx[i], drv[i]);
            end
            wq.push_back(16'h0BAD);
            avm_write(32'h30, 2'b11, 8'd1, w);
            tests++;
            if (w != wt[i]) begin
                fails++;
                $display("FAIL mem_latency waits got %0d expected %0d", w, wt[i]);
            end
        end
    endtask

    task automatic test_id_read();
        int w;
        exp_q.push_back(16'h0C81);
        avm_read(32'h8000_0000, 8'd1);
        exp_q.push_back(16'h0001);
        avm_read(32'h8000_0001, 8'd1);
        exp_q.push_back(16'hFFC1);
        avm_read(32'h8000_0801, 8'd1);
        exp_q.push_back(16'h0027);
        avm_read(32'h8000_0800, 8'd1);
        wq.push_back(16'h0000);
        avm_write(32'h8000_0000, 2'b11, 8'd1, w);
        exp_q.push_back(16'h0C81);
        avm_read(32'h8000_0000, 8'd1);
        wq.push_back(16'hAB00);
        avm_write(32'h8000_0801, 2'b10, 8'd1, w);
        exp_q.push_back(16'hABC1);
        avm_read(32'h8000_0801, 8'd1);
        exp_q.push_back(16'h0000);
        avm_read(32'h8000_1000, 8'd1);
    endtask

    task automatic test_reset_mid();
        int w, b0, guard;
        for (int i = 0; i < 8; i++) wq.push_back(16'h0100 + 16'(i));
        avm_write(32'h40, 2'b11, 8'd8, w);
        for (int i = 0; i < 8; i++) exp_q.push_back(16'h0100 + 16'(i));
        b0 = beats;
        avm_read_cmd(32'h40, 8'd8);
        guard = 0;
        while (beats < b0 + 3 && guard < 100) begin
            @(posedge clk);
            guard++;
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (readdatavalid !== 1'b0 || waitrequest !== 1'b1 || beats != b0 + 3) begin
            fails++;
            $display("FAIL reset_abort got rdv=%b wr=%b beats=%0d expected 0 1 %0d", readdatavalid, waitrequest, beats - b0, 3);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        tests++;
        if (beats != b0 + 3) begin
            fails++;
            $display("FAIL reset_no_beats got %0d beats expected 3", beats - b0);
        end
        exp_q.push_back(16'h8F1F);
        avm_read(32'h8000_0800, 8'd1);
        exp_q.push_back(16'h0102);
        avm_read(32'h42, 8'd1);
    endtask

    initial begin
        test_reset();
        test_latency_burst();
        test_byteenable();
        test_wrap();
        test_cfg();
        test_id_read();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
